// File: rtl/regfile_multiport.sv
// Integer register file: NREAD combinational read ports, one handshaked
// write port (IDLE/COMMIT), optional write-to-read bypass, hardwired x0
// and a per-register busy scoreboard used by decode for RAW hazards.
//
// Ports:
//   clk, reset        rising-edge clock, synchronous active-high reset
//   display           dump all registers at this edge (simulation only)
//   read_enable       0 forces every read_vals port to zero
//   read_regs         NREAD packed AW-bit read addresses
//   read_vals         NREAD packed XLEN-bit read data
//   read_busy         scoreboard bit of each port's addressed register
//   write_enable      write request, held until accepted
//   write_register    write destination
//   write_value       write data
//   write_ready       high in IDLE; request accepted when both high
//   write_done        one-cycle pulse after the commit edge
//   reserve_enable    mark reserve_register busy
//   reserve_register  register to reserve
//   busy_mask         current scoreboard, bit i = register i busy
module regfile_multiport #(
    parameter int XLEN   = 64,
    parameter int NREGS  = 32,
    parameter int NREAD  = 2,
    parameter bit BYPASS = 1'b1,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  display,
    input  logic                  read_enable,
    input  logic [NREAD*AW-1:0]   read_regs,
    output logic [NREAD*XLEN-1:0] read_vals,
    output logic [NREAD-1:0]      read_busy,
    input  logic                  write_enable,
    input  logic [AW-1:0]         write_register,
    input  logic [XLEN-1:0]       write_value,
    output logic                  write_ready,
    output logic                  write_done,
    input  logic                  reserve_enable,
    input  logic [AW-1:0]         reserve_register,
    output logic [NREGS-1:0]      busy_mask
);

    typedef enum logic {
        IDLE,
        COMMIT
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [AW-1:0]   pend_addr;
    logic [XLEN-1:0] pend_data;
    logic [XLEN-1:0] regs [NREGS];
    logic [NREGS-1:0] busy;
    logic [NREGS-1:0] busy_next;
    logic            accept;
    logic            commit;

    always_comb begin
        state_next  = state;
        write_ready = 1'b0;
        accept      = 1'b0;
        commit      = 1'b0;
        unique case (state)
            IDLE: begin
                write_ready = 1'b1;
                if (write_enable) begin
                    accept     = 1'b1;
                    state_next = COMMIT;
                end
            end
            COMMIT: begin
                commit     = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Clear before set so a fresh reservation at the commit edge wins.
    always_comb begin
        busy_next = busy;
        if (commit)
            busy_next[pend_addr] = 1'b0;
        if (reserve_enable)
            busy_next[reserve_register] = 1'b1;
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            write_done <= 1'b0;
            pend_addr  <= '0;
            pend_data  <= '0;
            busy       <= '0;
            for (int i = 0; i < NREGS; i++)
                regs[i] <= '0;
        end else begin
            state      <= state_next;
            write_done <= commit;
            busy       <= busy_next;
            if (accept) begin
                pend_addr <= write_register;
                pend_data <= write_value;
            end
            if (commit && pend_addr != '0)
                regs[pend_addr] <= pend_data;
        end
    end

    assign busy_mask = busy;

    for (genvar p = 0; p < NREAD; p++) begin : g_read
        logic [AW-1:0]   addr;
        logic [XLEN-1:0] val;

        assign addr = read_regs[p*AW +: AW];

        always_comb begin
            if (addr == '0)
                val = '0;
            else if (BYPASS && state == COMMIT && addr == pend_addr)
                val = pend_data;
            else
                val = regs[addr];
        end

        assign read_vals[p*XLEN +: XLEN] = read_enable ? val : '0;
        assign read_busy[p] = busy[addr];
    end

`ifndef SYNTHESIS
    function automatic string abi_name(input int i);
        string names [32] = '{
            "zero", "ra", "sp", "gp", "tp", "t0", "t1", "t2",
            "s0", "s1", "a0", "a1", "a2", "a3", "a4", "a5",
            "a6", "a7", "s2", "s3", "s4", "s5", "s6", "s7",
            "s8", "s9", "s10", "s11", "t3", "t4", "t5", "t6"
        };
        if (i < 32)
            return names[i];
        return "-";
    endfunction

    // Reads regs before the nonblocking updates of this edge land.
    always @(posedge clk) begin
        if (display) begin
            for (int i = 0; i < NREGS; i++)
                $display("%-4s x%0d = %0d", abi_name(i), i, regs[i]);
        end
    end
`endif

endmodule

// File: tb/tb_regfile_multiport.sv
// Directed bench for regfile_multiport: one bypassing and one
// non-bypassing instance driven from the same stimulus.
module tb_regfile_multiport;

    logic         clk = 1'b0;
    logic         reset;
    logic         display;
    logic         read_enable;
    logic [9:0]   read_regs;
    logic         write_enable;
    logic [4:0]   write_register;
    logic [63:0]  write_value;
    logic         reserve_enable;
    logic [4:0]   reserve_register;

    logic [127:0] rv1, rv0;
    logic [1:0]   rb1, rb0;
    logic         wr1, wr0, wd1, wd0;
    logic [31:0]  bm1, bm0;

    int vectors = 0;
    int miscompares = 0;

    localparam logic [63:0] V5 = 64'hDEAD_BEEF_0123_4567;

    always #5 clk = ~clk;

    regfile_multiport #(.BYPASS(1'b1)) dut (
        .clk(clk), .reset(reset), .display(display),
        .read_enable(read_enable), .read_regs(read_regs),
        .read_vals(rv1), .read_busy(rb1),
        .write_enable(write_enable), .write_register(write_register),
        .write_value(write_value), .write_ready(wr1), .write_done(wd1),
        .reserve_enable(reserve_enable),
        .reserve_register(reserve_register), .busy_mask(bm1)
    );

    regfile_multiport #(.BYPASS(1'b0)) dut0 (
        .clk(clk), .reset(reset), .display(display),
        .read_enable(read_enable), .read_regs(read_regs),
        .read_vals(rv0), .read_busy(rb0),
        .write_enable(write_enable), .write_register(write_register),
        .write_value(write_value), .write_ready(wr0), .write_done(wd0),
        .reserve_enable(reserve_enable),
        .reserve_register(reserve_register), .busy_mask(bm0)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rd(input logic [4:0] a0, input logic [4:0] a1);
        read_regs = {a1, a0};
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        read_enable = 1'b1;
        set_rd(5'd5, 5'd31);
        #1;
        vectors++;
        if (rv1 !== 128'd0) begin
            miscompares++;
            $display("FAIL reset_read got=%h want=0", rv1);
        end
        vectors++;
        if (bm1 !== 32'd0 || bm0 !== 32'd0) begin
            miscompares++;
            $display("FAIL reset_busy got=%h/%h want=0", bm1, bm0);
        end
        vectors++;
        if (wr1 !== 1'b1 || wd1 !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_hs ready=%b done=%b want 1/0", wr1, wd1);
        end
    endtask

    task automatic test_write();
        set_rd(5'd5, 5'd0);
        write_enable = 1'b1;
        write_register = 5'd5;
        write_value = V5;
        tick();
        write_enable = 1'b0;
        write_value = 64'd0;
        #1;
        vectors++;
        if (wr1 !== 1'b0 || wd1 !== 1'b0) begin
            miscompares++;
            $display("FAIL wr_commit ready=%b done=%b want 0/0", wr1, wd1);
        end
        vectors++;
        if (rv1[63:0] !== V5 || rv0[63:0] !== 64'd0) begin
            miscompares++;
            $display("FAIL wr_bypass got=%h/%h want=%h/0",
                     rv1[63:0], rv0[63:0], V5);
        end
        tick();
        vectors++;
        if (wd1 !== 1'b1 || wr1 !== 1'b1 || wd0 !== 1'b1) begin
            miscompares++;
            $display("FAIL wr_done done=%b ready=%b want 1/1", wd1, wr1);
        end
        vectors++;
        if (rv1[63:0] !== V5 || rv0[63:0] !== V5) begin
            miscompares++;
            $display("FAIL wr_value got=%h/%h want=%h",
                     rv1[63:0], rv0[63:0], V5);
        end
        tick();
        vectors++;
        if (wd1 !== 1'b0) begin
            miscompares++;
            $display("FAIL wr_done_pulse got=%b want=0", wd1);
        end
        read_enable = 1'b0;
        #1;
        vectors++;
        if (rv1 !== 128'd0 || rv0 !== 128'd0) begin
            miscompares++;
            $display("FAIL rd_gate got=%h/%h want=0", rv1, rv0);
        end
        read_enable = 1'b1;
    endtask

    task automatic test_bypass();
        set_rd(5'd5, 5'd5);
        write_enable = 1'b1;
        write_register = 5'd5;
        write_value = 64'd42;
        tick();
        write_enable = 1'b0;
        #1;
        vectors++;
        if (rv1 !== {64'd42, 64'd42}) begin
            miscompares++;
            $display("FAIL byp_on got=%h want=42 on both", rv1);
        end
        vectors++;
        if (rv0[63:0] !== V5) begin
            miscompares++;
            $display("FAIL byp_off got=%h want=%h", rv0[63:0], V5);
        end
        tick();
        vectors++;
        if (rv1[63:0] !== 64'd42 || rv0[63:0] !== 64'd42) begin
            miscompares++;
            $display("FAIL byp_after got=%h/%h want=42",
                     rv1[63:0], rv0[63:0]);
        end
    endtask

    task automatic test_x0();
        set_rd(5'd0, 5'd0);
        write_enable = 1'b1;
        write_register = 5'd0;
        write_value = 64'd7;
        reserve_enable = 1'b1;
        reserve_register = 5'd0;
        tick();
        write_enable = 1'b0;
        reserve_enable = 1'b0;
        #1;
        vectors++;
        if (rv1 !== 128'd0) begin
            miscompares++;
            $display("FAIL x0_bypass got=%h want=0", rv1);
        end
        tick();
        vectors++;
        if (wd1 !== 1'b1) begin
            miscompares++;
            $display("FAIL x0_done got=%b want=1", wd1);
        end
        vectors++;
        if (rv1 !== 128'd0 || rv0 !== 128'd0 || bm1[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL x0_read got=%h busy0=%b want=0/0", rv1, bm1[0]);
        end
        tick();
    endtask

    task automatic test_scoreboard();
        set_rd(5'd3, 5'd10);
        reserve_enable = 1'b1;
        reserve_register = 5'd10;
        tick();
        reserve_enable = 1'b0;
        #1;
        vectors++;
        if (bm1 !== 32'h0000_0400 || rb1 !== 2'b10) begin
            miscompares++;
            $display("FAIL sb_reserve mask=%h rb=%b want=400/10", bm1, rb1);
        end
        // re-reserving a busy register keeps it busy
        reserve_enable = 1'b1;
        tick();
        reserve_enable = 1'b0;
        #1;
        vectors++;
        if (bm1 !== 32'h0000_0400) begin
            miscompares++;
            $display("FAIL sb_rereserve mask=%h want=400", bm1);
        end
        write_enable = 1'b1;
        write_register = 5'd10;
        write_value = 64'd100;
        tick();
        write_enable = 1'b0;
        #1;
        vectors++;
        if (bm1[10] !== 1'b1) begin
            miscompares++;
            $display("FAIL sb_in_commit got=%b want=1", bm1[10]);
        end
        tick();
        vectors++;
        if (bm1 !== 32'd0 || rb1 !== 2'b00 || rv1[127:64] !== 64'd100) begin
            miscompares++;
            $display("FAIL sb_clear mask=%h val=%0d want=0/100",
                     bm1, rv1[127:64]);
        end
        // reservation at the commit edge wins
        write_enable = 1'b1;
        write_value = 64'd101;
        tick();
        write_enable = 1'b0;
        reserve_enable = 1'b1;
        reserve_register = 5'd10;
        tick();
        reserve_enable = 1'b0;
        #1;
        vectors++;
        if (bm1 !== 32'h0000_0400 || wd1 !== 1'b1) begin
            miscompares++;
            $display("FAIL sb_set_wins mask=%h done=%b want=400/1", bm1, wd1);
        end
    endtask

    task automatic test_back_to_back();
        set_rd(5'd1, 5'd2);
        write_enable = 1'b1;
        write_register = 5'd1;
        write_value = 64'd1;
        tick();
        write_register = 5'd2;
        write_value = 64'd2;
        tick();
        vectors++;
        if (wd1 !== 1'b1 || wr1 !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b_overlap done=%b ready=%b want=1/1", wd1, wr1);
        end
        tick();
        write_enable = 1'b0;
        #1;
        vectors++;
        if (wr1 !== 1'b0 || wd1 !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_second ready=%b done=%b want=0/0", wr1, wd1);
        end
        tick();
        vectors++;
        if (rv1 !== {64'd2, 64'd1} || rv0 !== {64'd2, 64'd1}) begin
            miscompares++;
            $display("FAIL b2b_values got=%h want=2/1", rv0);
        end
    endtask

    task automatic test_reset_in_flight();
        set_rd(5'd9, 5'd1);
        reserve_enable = 1'b1;
        reserve_register = 5'd7;
        write_enable = 1'b1;
        write_register = 5'd9;
        write_value = 64'd9;
        tick();
        reserve_enable = 1'b0;
        write_enable = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        vectors++;
        if (rv1 !== 128'd0 || rv0 !== 128'd0) begin
            miscompares++;
            $display("FAIL rst_flight_vals got=%h want=0", rv1);
        end
        vectors++;
        if (wd1 !== 1'b0 || wr1 !== 1'b1 || bm1 !== 32'd0) begin
            miscompares++;
            $display("FAIL rst_flight_hs done=%b ready=%b mask=%h want=0/1/0",
                     wd1, wr1, bm1);
        end
        tick();
        vectors++;
        if (wd1 !== 1'b0 || rv1 !== 128'd0) begin
            miscompares++;
            $display("FAIL rst_flight_late done=%b val=%h want=0/0", wd1, rv1);
        end
    endtask

    initial begin
        reset = 1'b1;
        display = 1'b0;
        read_enable = 1'b0;
        read_regs = '0;
        write_enable = 1'b0;
        write_register = '0;
        write_value = '0;
        reserve_enable = 1'b0;
        reserve_register = '0;

        test_reset();
        test_write();
        test_bypass();
        test_x0();
        test_scoreboard();
        test_back_to_back();
        test_reset_in_flight();

        display = 1'b1;
        tick();
        display = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
